// File: rtl/block_ram_port_arbiter_if.sv
// Requester and RAM-port bundle for block_ram_port_arbiter.
// reqLock/arbLocked exist only when BLOCK_RAM_ARB_LOCK_EN is defined.
interface block_ram_port_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_BYTES  = 2,
  parameter int PARITY_BITS = 0,
  parameter int ADDR_WIDTH  = 10
);
  localparam int DATA_WIDTH = DATA_BYTES * (8 + PARITY_BITS);

  logic [NUM_REQ-1:0]            reqValid;
  logic [NUM_REQ-1:0]            reqReady;
  logic [NUM_REQ*DATA_BYTES-1:0] reqWriteEnable;
  logic [NUM_REQ*ADDR_WIDTH-1:0] reqAddress;
  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataIn;
  logic [NUM_REQ-1:0]            respValid;
  logic [DATA_WIDTH-1:0]         respData;
  logic                          ramEnable;
  logic [DATA_BYTES-1:0]         ramWriteEnable;
  logic [ADDR_WIDTH-1:0]         ramAddress;
  logic [DATA_WIDTH-1:0]         ramDataIn;
  logic [DATA_WIDTH-1:0]         ramDataOut;
`ifdef BLOCK_RAM_ARB_LOCK_EN
  logic [NUM_REQ-1:0]            reqLock;
  logic                          arbLocked;
`endif

  modport master (
    output reqValid, reqWriteEnable, reqAddress, reqDataIn,
    output ramDataOut,
`ifdef BLOCK_RAM_ARB_LOCK_EN
    output reqLock,
    input  arbLocked,
`endif
    input  reqReady, respValid, respData,
    input  ramEnable, ramWriteEnable, ramAddress, ramDataIn
  );

  modport slave (
    input  reqValid, reqWriteEnable, reqAddress, reqDataIn,
    input  ramDataOut,
`ifdef BLOCK_RAM_ARB_LOCK_EN
    input  reqLock,
    output arbLocked,
`endif
    output reqReady, respValid, respData,
    output ramEnable, ramWriteEnable, ramAddress, ramDataIn
  );
endinterface

// File: rtl/block_ram_port_arbiter.sv
// Round-robin arbiter sharing one block RAM port among NUM_REQ requesters.
// Optional lock feature: define BLOCK_RAM_ARB_LOCK_EN.
module block_ram_port_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_BYTES  = 2,
  parameter int PARITY_BITS = 0,
  parameter int ADDR_WIDTH  = 10
) (
  input logic clock,
  input logic reset,
  block_ram_port_arbiter_if.slave bus
);
  localparam int DATA_WIDTH = DATA_BYTES * (8 + PARITY_BITS);
  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      gidx;
  logic [PW-1:0]      idx;
  logic [PW-1:0]      nxt;
  logic [PW:0]        sum;
  logic               found;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] resp_valid;

`ifdef BLOCK_RAM_ARB_LOCK_EN
  logic          locked;
  logic [PW-1:0] owner;
`endif

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    sum   = '0;
    grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ))
        sum = sum - (PW+1)'(NUM_REQ);
      idx = sum[PW-1:0];
      if (!found && bus.reqValid[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
`ifdef BLOCK_RAM_ARB_LOCK_EN
    // the lock owner is the only candidate while locked
    if (locked) begin
      found = bus.reqValid[owner];
      gidx  = owner;
    end
`endif
    if (reset)
      found = 1'b0;
    if (found)
      grant[gidx] = 1'b1;
  end

  assign nxt = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);

  always_comb begin
    bus.ramEnable      = 1'b0;
    bus.ramWriteEnable = '0;
    bus.ramAddress     = bus.reqAddress[ADDR_WIDTH-1:0];
    bus.ramDataIn      = bus.reqDataIn[DATA_WIDTH-1:0];
    if (found) begin
      bus.ramEnable      = 1'b1;
      bus.ramWriteEnable =
        bus.reqWriteEnable[int'(gidx)*DATA_BYTES +: DATA_BYTES];
      bus.ramAddress     =
        bus.reqAddress[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.ramDataIn      =
        bus.reqDataIn[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      resp_valid <= '0;
`ifdef BLOCK_RAM_ARB_LOCK_EN
      locked     <= 1'b0;
      owner      <= '0;
`endif
    end else begin
      resp_valid <= grant;
`ifdef BLOCK_RAM_ARB_LOCK_EN
      if (found) begin
        if (!locked) begin
          rr_ptr <= nxt;
          if (bus.reqLock[gidx]) begin
            locked <= 1'b1;
            owner  <= gidx;
          end
        end else if (!bus.reqLock[gidx]) begin
          locked <= 1'b0;
          rr_ptr <= nxt;
        end
      end
`else
      if (found)
        rr_ptr <= nxt;
`endif
    end
  end

  assign bus.reqReady  = grant;
  assign bus.respValid = resp_valid;
  assign bus.respData  = bus.ramDataOut;
`ifdef BLOCK_RAM_ARB_LOCK_EN
  assign bus.arbLocked = locked;
`endif
endmodule

// File: doc/block_ram_port_arbiter.md
Name: block_ram_port_arbiter

Overview:
Round-robin arbiter that shares one read/write port of a dual-port block RAM among NUM_REQ requesters. It accepts at most one request per cycle through a valid/ready handshake and drives the RAM port enable, byte write enables, address and write data. It returns the RAM's registered read data to the granted requester one cycle after acceptance. It sits between client engines (DMA, CPU bus bridge, video fetch) and one port of the block RAM; the other RAM port stays free for a dedicated client.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_BYTES, 2, byte columns per word; must match the RAM
PARITY_BITS, 0, extra bits per column (column width = 8 + PARITY_BITS)
ADDR_WIDTH, 10, RAM address width
DATA_WIDTH (localparam), DATA_BYTES*(8+PARITY_BITS)

Ports:
clock  in  1  single clock; the RAM port is clocked from the same net
reset  in  1  asynchronous, active-high reset
reqValid  in  NUM_REQ  request valid, one bit per requester
reqReady  out  NUM_REQ  one-hot grant; request i is accepted when reqValid[i] && reqReady[i]
reqWriteEnable  in  NUM_REQ*DATA_BYTES  per-requester byte write enables; all zero = read
reqAddress  in  NUM_REQ*ADDR_WIDTH  per-requester address, requester i at slice i
reqDataIn  in  NUM_REQ*DATA_WIDTH  per-requester write data
respValid  out  NUM_REQ  one-hot; response for requester i is valid this cycle
respData  out  DATA_WIDTH  response data, shared by all requesters
ramEnable  out  1  to RAM enable
ramWriteEnable  out  DATA_BYTES  to RAM byte write enables
ramAddress  out  ADDR_WIDTH  to RAM address
ramDataIn  out  DATA_WIDTH  to RAM write data
ramDataOut  in  DATA_WIDTH  from the RAM registered data output (read-first)

Behaviour:
- Grant is combinational from reqValid and the priority pointer rrPtr.
  - Search order: rrPtr, rrPtr+1, …, wrapping modulo NUM_REQ.
  - The first requester with reqValid set receives reqReady. At most one reqReady bit is set.
- reqReady does not depend on any requester's ready-like input, so there is no combinational loop. A requester may drop reqValid without being accepted (no stickiness required).
- On an accepted cycle:
  - ramEnable=1.
  - ramWriteEnable, ramAddress and ramDataIn are muxed from the granted slice.
- On an idle cycle:
  - ramEnable=0, ramWriteEnable=0.
  - ramAddress and ramDataIn are held at slice 0 (don't care).
- At the clock edge after an acceptance by requester g, rrPtr <= (g+1) mod NUM_REQ. rrPtr is unchanged on idle cycles.
- Response:
  - respValid is a register. respValid <= one-hot(g) at the edge that accepts; it is 0 otherwise.
  - respValid is asserted for reads and writes alike. Latency is exactly 1 cycle after acceptance.
  - respData = ramDataOut (combinational pass-through). For writes it returns the pre-write word (read-first).
- Back-to-back accepts are allowed every cycle, giving full throughput. There is no response backpressure: requesters must sink respValid.
- Fairness: with all NUM_REQ requesters continuously valid, each is granted exactly once per NUM_REQ cycles.
- Reset (asynchronous):
  - rrPtr=0, respValid=0.
  - While reset is high, reqReady=0, ramEnable=0, ramWriteEnable=0.
  - A request in flight when reset asserts is dropped, and its response is never delivered.
- Deassertion of reset is assumed synchronised externally. The first grant can occur in the first cycle after release.

Optional Feature:
BLOCK_RAM_ARB_LOCK_EN
- With the macro defined, the block adds input reqLock[NUM_REQ] and output arbLocked (1 bit, reset 0).
- Lock start: when requester g is accepted with reqLock[g]=1, arbLocked<=1 and lockOwner<=g.
- While arbLocked=1:
  - Only lockOwner can receive reqReady. Other requesters are blocked.
  - If lockOwner's reqValid is low, the RAM port idles.
  - rrPtr is not updated.
- Lock release: an accepted beat from lockOwner with reqLock=0 clears arbLocked and sets rrPtr=(lockOwner+1) mod NUM_REQ.
- Reset clears the lock.
- Without the macro, there is no reqLock port, no arbLocked port and no lock state; arbitration is pure round-robin.

Test Plan:
1. Reset release; requester 2 alone: valid, read address 0x005 (RAM holds 0xBEEF) -> reqReady=0100 the same cycle; respValid=0100 and respData=0xBEEF the next cycle; rrPtr=3.
2. All 4 requesters valid for 8 cycles starting at rrPtr=0 -> grants 0,1,2,3,0,1,2,3 one per cycle; respValid follows the same sequence one cycle later.
3. Req1 writes 0x1234 with byte enables 01 to address 0x010 (old 0xAAAA) -> its response returns 0xAAAA; a following read of 0x010 returns 0xAA34.
4. Req0 and req3 valid simultaneously with rrPtr=1 -> req3 is granted first, then req0; rrPtr ends at 1.
5. Reset asserted asynchronously in the cycle after req1 is accepted -> respValid goes to 0 immediately and stays 0 after release; ramEnable=0 during reset.
6. With BLOCK_RAM_ARB_LOCK_EN: req2 is accepted with lock, then req0 and req2 are valid for 3 beats, the last with reqLock=0 -> req0 is blocked for all 3 beats, is granted on the 4th cycle, and arbLocked falls after the 3rd beat.
